mem_to_axilite_master: RTL and testbench

Bridges the PicoRV32 native memory interface (mem_valid/mem_ready) to an AXI-Lite master port. It sits directly upstream of the team's AXI-Lite slave bridge and drives that bridge's five channels.
- One transaction is outstanding at a time.
- A request is a write when mem_wstrb != 0; otherwise it is a read.
- A non-OKAY response is reported through a sticky error flag and a captured error address.

---
 rtl/mem_to_axilite_master_pkg.sv | 23 ++
 rtl/mem_to_axilite_master_err_capture.sv | 28 ++
 rtl/mem_to_axilite_master.sv | 162 ++++++++++++++++
 tb/tb_mem_to_axilite_master.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_to_axilite_master_pkg.sv
// Shared definitions for the PicoRV32-native to AXI-Lite master bridge:
// FSM state encoding and AXI response codes.
package mem_to_axilite_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Anything other than OKAY is treated as a bus error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/mem_to_axilite_master_err_capture.sv
// Sticky bus-error flag with first-error address capture; a clear that
// coincides with a new error lets the new error win.
module axil_err_capture #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  err_set,
  input  logic [ADDR_WIDTH-1:0] err_addr_in,
  input  logic                  err_clr,
  output logic                  bus_err,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else if (err_set && (!bus_err || err_clr)) begin
      bus_err  <= 1'b1;
      err_addr <= err_addr_in;
    end else if (err_clr) begin
      bus_err  <= 1'b0;
      err_addr <= '0;
    end
  end

endmodule

// File: rtl/mem_to_axilite_master.sv
// Bridges the PicoRV32 native memory port to a single-outstanding AXI-Lite
// master. Writes when mem_wstrb != 0, reads otherwise.
module mem_to_axilite_master
  import mem_to_axilite_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mem_valid,
  input  logic                    mem_instr,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    mem_ready,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready,
  output logic                    bus_err,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  input  logic                    err_clr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Handshake rule on every AXI channel: a transfer happens on the rising
  // edge where valid && ready; once raised, a valid and its payload stay
  // unchanged until that edge.
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   awaddr_d, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_d, mem_rdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_d;
  logic [2:0]              arprot_d;
  logic                    awvalid_d, wvalid_d, arvalid_d, mem_ready_d;
  logic                    err_set;
  logic [ADDR_WIDTH-1:0]   err_addr_in;

  assign awprot = 3'b000;
  assign bready = (state_q == ST_WRESP);
  assign rready = (state_q == ST_RDATA);

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr;
    wdata_d     = wdata;
    wstrb_d     = wstrb;
    awvalid_d   = awvalid;
    wvalid_d    = wvalid;
    araddr_d    = araddr;
    arprot_d    = arprot;
    arvalid_d   = arvalid;
    mem_rdata_d = mem_rdata;
    err_set     = 1'b0;
    err_addr_in = awaddr;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          if (|mem_wstrb) begin
            awaddr_d  = mem_addr;
            wdata_d   = mem_wdata;
            wstrb_d   = mem_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WADDR;
          end else begin
            araddr_d  = mem_addr;
            arprot_d  = {mem_instr, 2'b00};
            arvalid_d = 1'b1;
            state_d   = ST_RADDR;
          end
        end
      end
      ST_WADDR: begin
        // AW and W complete independently, in either order or together.
        if (awvalid && awready) awvalid_d = 1'b0;
        if (wvalid && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        if (bvalid) begin
          state_d     = ST_DONE;
          err_set     = resp_is_err(bresp);
          err_addr_in = awaddr;
        end
      end
      ST_RADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (rvalid) begin
          mem_rdata_d = rdata;
          state_d     = ST_DONE;
          err_set     = resp_is_err(rresp);
          err_addr_in = araddr;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    mem_ready_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      awaddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      araddr    <= '0;
      arprot    <= 3'b000;
      arvalid   <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      awaddr    <= awaddr_d;
      wdata     <= wdata_d;
      wstrb     <= wstrb_d;
      awvalid   <= awvalid_d;
      wvalid    <= wvalid_d;
      araddr    <= araddr_d;
      arprot    <= arprot_d;
      arvalid   <= arvalid_d;
      mem_ready <= mem_ready_d;
      mem_rdata <= mem_rdata_d;
    end
  end

  axil_err_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_err_capture (
    .clk         (clk),
    .resetn      (resetn),
    .err_set     (err_set),
    .err_addr_in (err_addr_in),
    .err_clr     (err_clr),
    .bus_err     (bus_err),
    .err_addr    (err_addr)
  );

endmodule

// File: tb/tb_mem_to_axilite_master.sv
// Directed bench for mem_to_axilite_master: core driver tasks, a delay-
// configurable AXI-Lite slave, and a scoreboard monitor on the falling edge.
module tb_mem_to_axilite_master;
  import mem_to_axilite_master_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          mem_valid, mem_instr, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] awaddr, araddr, err_addr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, bus_err, err_clr;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  mem_to_axilite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .bus_err(bus_err), .err_addr(err_addr), .err_clr(err_clr)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0]   exp_aw_q[$];
  logic [DW+3:0]   exp_w_q[$];
  logic [AW+2:0]   exp_ar_q[$];
  logic [DW:0]     exp_rsp_q[$];   // {is_read, rdata}

  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]    cfg_bresp = RESP_OKAY;
  logic [1:0]    cfg_rresp = RESP_OKAY;
  logic [DW-1:0] cfg_rdata = '0;

  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not seen / unexpected", name);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({mem_ready, awvalid, wvalid, arvalid, bready, rready, bus_err}), 64'd0);
    check({tag, "_awaddr"},   64'(awaddr),    64'd0);
    check({tag, "_wdata"},    64'(wdata),     64'd0);
    check({tag, "_araddr"},   64'(araddr),    64'd0);
    check({tag, "_err_addr"}, 64'(err_addr),  64'd0);
    check({tag, "_misc"},     64'({wstrb, arprot, awprot, mem_rdata}), 64'd0);
  endtask

  // ---------------- AXI-Lite slave model ----------------
  initial begin : slave_aw
    int cnt;
    cnt = 0; awready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!resetn || !awvalid) begin awready = 1'b0; cnt = 0; end
      else if (cnt >= aw_delay) awready = 1'b1;
      else begin awready = 1'b0; cnt++; end
    end
  end

  initial begin : slave_w
    int cnt;
    cnt = 0; wready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!resetn || !wvalid) begin wready = 1'b0; cnt = 0; end
      else if (cnt >= w_delay) wready = 1'b1;
      else begin wready = 1'b0; cnt++; end
    end
  end

  initial begin : slave_ar
    int cnt;
    cnt = 0; arready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!resetn || !arvalid) begin arready = 1'b0; cnt = 0; end
      else if (cnt >= ar_delay) arready = 1'b1;
      else begin arready = 1'b0; cnt++; end
    end
  end

  initial begin : slave_b
    int cnt, done;
    cnt = 0; done = 0; bvalid = 1'b0; bresp = RESP_OKAY;
    forever begin
      @(posedge clk); #2;
      if (!resetn) begin bvalid = 1'b0; cnt = 0; done = 0; end
      else if (bvalid) begin
        if (b_hs_n > done) begin bvalid = 1'b0; done = b_hs_n; end
      end else if (aw_hs_n > done && w_hs_n > done) begin
        if (cnt >= b_delay) begin bvalid = 1'b1; bresp = cfg_bresp; cnt = 0; end
        else cnt++;
      end
    end
  end

  initial begin : slave_r
    int cnt, done;
    cnt = 0; done = 0; rvalid = 1'b0; rresp = RESP_OKAY; rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (!resetn) begin rvalid = 1'b0; cnt = 0; done = 0; end
      else if (rvalid) begin
        if (r_hs_n > done) begin rvalid = 1'b0; done = r_hs_n; end
      end else if (ar_hs_n > done) begin
        if (cnt >= r_delay) begin
          rvalid = 1'b1; rresp = cfg_rresp; rdata = cfg_rdata; cnt = 0;
        end else cnt++;
      end
    end
  end

  // ---------------- monitor ----------------
  logic          p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_mrdy = 0;
  logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
  logic [DW-1:0] p_wdata = '0;

  always @(negedge clk) begin
    if (!resetn) begin
      aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; ar_hs_n = 0; r_hs_n = 0;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_mrdy = 0;
    end else begin
      if (p_awv && !p_awr) check("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, p_awaddr}));
      if (p_wv && !p_wr)   check("w_hold",  64'({wvalid, wdata}),   64'({1'b1, p_wdata}));
      if (p_arv && !p_arr) check("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, p_araddr}));
      if (awvalid && awready) begin
        aw_hs_n++; aw_hs_cyc = cyc;
        if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
        else check("aw_addr", 64'({awprot, awaddr}), 64'({3'b000, exp_aw_q.pop_front()}));
      end
      if (wvalid && wready) begin
        w_hs_n++; w_hs_cyc = cyc;
        if (exp_w_q.size() == 0) fail_now("w_unexpected");
        else check("w_data", 64'({wstrb, wdata}), 64'(exp_w_q.pop_front()));
      end
      if (arvalid && arready) begin
        ar_hs_n++;
        if (exp_ar_q.size() == 0) fail_now("ar_unexpected");
        else check("ar_addr", 64'({arprot, araddr}), 64'(exp_ar_q.pop_front()));
      end
      if (bvalid && bready) b_hs_n++;
      if (rvalid && rready) r_hs_n++;
      if (mem_ready) begin
        logic [DW:0] e;
        check("mem_ready_pulse", 64'(p_mrdy), 64'd0);
        if (exp_rsp_q.size() == 0) fail_now("rsp_unexpected");
        else begin
          e = exp_rsp_q.pop_front();
          if (e[DW]) check("mem_rdata", 64'(mem_rdata), 64'(e[DW-1:0]));
        end
      end
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid;   p_wr = wready;   p_wdata = wdata;
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
      p_mrdy = mem_ready;
    end
  end

  // ---------------- core-side driver ----------------
  // Called at posedge+2; returns at posedge+2 after the completing edge.
  task automatic do_req(input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [3:0] strb, input logic instr,
                        input logic [DW-1:0] exp_rd, output int lat);
    if (strb != 4'h0) begin
      exp_aw_q.push_back(addr);
      exp_w_q.push_back({strb, wd});
      exp_rsp_q.push_back({1'b0, {DW{1'b0}}});
    end else begin
      exp_ar_q.push_back({instr, 2'b00, addr});
      exp_rsp_q.push_back({1'b1, exp_rd});
    end
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = strb; mem_instr = instr;
    lat = 0;
    forever begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (mem_ready) break;
      if (lat >= 60) begin fail_now("mem_ready_timeout"); break; end
    end
    @(posedge clk); #2;
    mem_valid = 1'b0; mem_wstrb = 4'h0; mem_instr = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int lat, lat2, lat3, a0, r0, b0;
    resetn = 1'b0; err_clr = 1'b0;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #2 resetn = 1'b1;
    @(posedge clk); #2;

    // plain write, everything ready immediately
    do_req(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, '0, lat);
    check("wr_latency", 64'(lat), 64'd3);
    check("wr_aw_w_same_cycle", 64'(aw_hs_cyc - w_hs_cyc), 64'd0);
    check("wr_bus_err", 64'(bus_err), 64'd0);
    check("wr_awaddr_stable", 64'(awaddr), 64'h10);
    check("wr_wdata_stable", 64'(wdata), 64'hDEAD_BEEF);

    // instruction fetch with a 4-cycle rvalid delay
    r_delay = 4; cfg_rdata = 32'h1234_5678;
    do_req(32'h20, '0, 4'h0, 1'b1, 32'h1234_5678, lat);
    check("rd_latency", 64'(lat), 64'd7);
    check("rd_arprot_stable", 64'(arprot), 64'd4);
    r_delay = 0;

    // W completes two cycles before AW
    aw_delay = 2; b0 = b_hs_n;
    do_req(32'h30, 32'hA5A5_5A5A, 4'b0011, 1'b0, '0, lat);
    check("wr_w_before_aw", 64'(aw_hs_cyc - w_hs_cyc), 64'd2);
    check("wr_split_b_count", 64'(b_hs_n - b0), 64'd1);
    check("wr_split_latency", 64'(lat), 64'd5);
    aw_delay = 0;

    // read error, then write error: first error is held
    cfg_rresp = RESP_SLVERR; cfg_rdata = 32'hCAFE_F00D;
    do_req(32'h40, '0, 4'h0, 1'b0, 32'hCAFE_F00D, lat);
    check("rderr_bus_err", 64'(bus_err), 64'd1);
    check("rderr_err_addr", 64'(err_addr), 64'h40);
    cfg_rresp = RESP_OKAY; cfg_bresp = RESP_DECERR;
    do_req(32'h44, 32'h1111_2222, 4'hF, 1'b0, '0, lat);
    check("held_bus_err", 64'(bus_err), 64'd1);
    check("held_err_addr", 64'(err_addr), 64'h40);
    err_clr = 1'b1; @(posedge clk); #2 err_clr = 1'b0;
    check("clr_bus_err", 64'(bus_err), 64'd0);
    check("clr_err_addr", 64'(err_addr), 64'd0);
    do_req(32'h44, 32'h3333_4444, 4'hF, 1'b0, '0, lat);
    check("wrerr_err_addr", 64'(err_addr), 64'h44);

    // clear held across a new error: new error wins
    cfg_bresp = RESP_OKAY; cfg_rresp = RESP_DECERR; cfg_rdata = 32'h0;
    fork
      do_req(32'h48, '0, 4'h0, 1'b0, 32'h0, lat);
      begin
        err_clr = 1'b1;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (mem_ready) break;
        end
        err_clr = 1'b0;
      end
    join
    check("clr_vs_new_bus_err", 64'(bus_err), 64'd1);
    check("clr_vs_new_err_addr", 64'(err_addr), 64'h48);
    cfg_rresp = RESP_OKAY;
    err_clr = 1'b1; @(posedge clk); #2 err_clr = 1'b0;

    // reset while waiting in WRESP
    b_delay = 10;
    exp_aw_q.push_back(32'h50); exp_w_q.push_back({4'hF, 32'h55AA_55AA});
    mem_valid = 1'b1; mem_addr = 32'h50; mem_wdata = 32'h55AA_55AA; mem_wstrb = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bready) break;
    end
    check("reached_wresp", 64'(bready), 64'd1);
    #1 resetn = 1'b0;
    #1 check_all_zero("async_reset");
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1; b_delay = 0;
    exp_aw_q.delete(); exp_w_q.delete();
    @(posedge clk); #2;
    cfg_rdata = 32'h0BAD_F00D;
    do_req(32'h0, '0, 4'h0, 1'b0, 32'h0BAD_F00D, lat);
    check("post_reset_rd_latency", 64'(lat), 64'd3);

    // back-to-back requests, mem_valid re-asserted right after mem_ready
    a0 = aw_hs_n; r0 = ar_hs_n; b0 = b_hs_n;
    cfg_rdata = 32'h600D_CAFE;
    do_req(32'h100, 32'h0102_0304, 4'b1000, 1'b0, '0, lat);
    do_req(32'h104, '0, 4'h0, 1'b0, 32'h600D_CAFE, lat2);
    do_req(32'h108, 32'h0506_0708, 4'hF, 1'b0, '0, lat3);
    check("b2b_latencies", 64'({lat[7:0], lat2[7:0], lat3[7:0]}), 64'h03_03_03);
    check("b2b_aw_count", 64'(aw_hs_n - a0), 64'd2);
    check("b2b_ar_count", 64'(ar_hs_n - r0), 64'd1);
    check("b2b_b_count", 64'(b_hs_n - b0), 64'd2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queues_drained", 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_rsp_q.size()), 64'd0);
    check("idle_outputs", 64'({mem_ready, awvalid, wvalid, arvalid, bready, rready}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
